// File: rtl/cdec8_run_ctrl.sv
// -----------------------------------------------------------------------------
// cdec8_run_ctrl
// Run sequencer for the CDEC8 core. It loads a program into the shared 256x8
// memory from a host byte stream, then resets and releases the core, and
// watches endseq under a cycle timeout. When the core halts, it reads the
// result registers through resad/resdt and emits them as a byte stream.
// The memory port belongs to the loader in LOAD and is passed through from the
// core in RUN.
//
// Ports
//   clock, reset_N              clock (rising edge), async active-low reset
//   cmd_load, cmd_run           1-cycle command pulses (accepted in IDLE/DONE)
//   cmd_abort                   level, returns to IDLE from any state
//   ld_valid/ld_data/ld_last    host program byte stream, ld_ready handshake
//   cpu_rst_N                   active-low reset to the core
//   cpu_adrs/cpu_wdata/cpu_mmwr_en  core memory port (used only in RUN)
//   mem_adrs/mem_wdata/mem_we   shared memory write port
//   endseq                      core halted
//   resad/resdt                 result register select / data
//   dmp_valid/dmp_data/dmp_ready result byte stream
//   busy, done, timeout         status (done/timeout sticky until next command)
// -----------------------------------------------------------------------------
module cdec8_run_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int TIMEOUT   = 65535,
  parameter int DUMP_LEN  = 16
) (
  input  logic       clock,
  input  logic       reset_N,
  input  logic       cmd_load,
  input  logic       cmd_run,
  input  logic       cmd_abort,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  output logic       ld_ready,
  output logic       cpu_rst_N,
  input  logic [7:0] cpu_adrs,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_mmwr_en,
  output logic [7:0] mem_adrs,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic       endseq,
  output logic [7:0] resad,
  input  logic [7:0] resdt,
  output logic       dmp_valid,
  output logic [7:0] dmp_data,
  input  logic       dmp_ready,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN_RST, S_RUN, S_DUMP_ADR, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [7:0]  LAST_ADR = 8'(MEM_DEPTH - 1);
  localparam logic [15:0] TMO_VAL  = 16'(TIMEOUT);
  localparam logic [7:0]  LAST_IDX = 8'(DUMP_LEN - 1);

  state_t      state_reg, state_next;
  logic [7:0]  ptr_reg, ptr_next;
  logic [15:0] timer_reg, timer_next;
  logic [7:0]  idx_reg, idx_next;
  logic        cpu_rst_n_reg, cpu_rst_n_next;
  logic        ld_ready_reg, ld_ready_next;
  logic        mem_we_reg, mem_we_next;
  logic [7:0]  mem_adrs_reg, mem_adrs_next;
  logic [7:0]  mem_wdata_reg, mem_wdata_next;
  logic [7:0]  resad_reg, resad_next;
  logic        dmp_valid_reg, dmp_valid_next;
  logic [7:0]  dmp_data_reg, dmp_data_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        timeout_reg, timeout_next;
  logic        ld_accept;

  // ld_ready_reg is only ever high in LOAD, but qualify anyway so a stray
  // ld_valid can never produce a write.
  assign ld_accept = ld_valid & ld_ready_reg & (state_reg == S_LOAD);

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    timer_next     = timer_reg;
    idx_next       = idx_reg;
    mem_we_next    = 1'b0;
    mem_adrs_next  = mem_adrs_reg;
    mem_wdata_next = mem_wdata_reg;
    resad_next     = resad_reg;
    dmp_valid_next = dmp_valid_reg;
    dmp_data_next  = dmp_data_reg;
    done_next      = done_reg;
    timeout_next   = timeout_reg;

    if (cmd_abort) begin
      // Abort beats every other transition; status flags are left alone.
      state_next     = S_IDLE;
      dmp_valid_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (cmd_load) begin
            state_next   = S_LOAD;
            ptr_next     = 8'd0;
            done_next    = 1'b0;
            timeout_next = 1'b0;
          end else if (cmd_run) begin
            state_next   = S_RUN_RST;
            done_next    = 1'b0;
            timeout_next = 1'b0;
          end
        end
        S_LOAD: begin
          if (ld_accept) begin
            mem_we_next    = 1'b1;
            mem_adrs_next  = ptr_reg;
            mem_wdata_next = ld_data;
            // The final address ends the load instead of wrapping to 0.
            if (ld_last || (ptr_reg == LAST_ADR)) state_next = S_IDLE;
            else                                 ptr_next   = ptr_reg + 8'd1;
          end
        end
        S_RUN_RST: begin
          timer_next = 16'd0;
          state_next = S_RUN;
        end
        S_RUN: begin
          // timer reads 0 in the first RUN cycle, so the abort fires in the
          // cycle where it has counted up to TIMEOUT. endseq has priority.
          if (endseq) begin
            state_next = S_DUMP_ADR;
            idx_next   = 8'd0;
            resad_next = 8'd0;
          end else if (timer_reg == TMO_VAL) begin
            state_next   = S_DONE;
            done_next    = 1'b1;
            timeout_next = 1'b1;
          end else begin
            timer_next = timer_reg + 16'd1;
          end
        end
        S_DUMP_ADR: begin
          // resad has been stable for this whole cycle; resdt is now valid.
          state_next     = S_DUMP_OUT;
          dmp_data_next  = resdt;
          dmp_valid_next = 1'b1;
        end
        S_DUMP_OUT: begin
          if (dmp_ready) begin
            dmp_valid_next = 1'b0;
            if (idx_reg == LAST_IDX) begin
              state_next = S_DONE;
              done_next  = 1'b1;
            end else begin
              idx_next   = idx_reg + 8'd1;
              resad_next = idx_reg + 8'd1;
              state_next = S_DUMP_ADR;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    // Registered outputs follow the state being entered so they line up
    // with state_reg in the following cycle.
    cpu_rst_n_next = (state_next == S_RUN) || (state_next == S_DUMP_ADR) ||
                     (state_next == S_DUMP_OUT);
    ld_ready_next  = (state_next == S_LOAD);
    busy_next      = (state_next != S_IDLE) && (state_next != S_DONE);
  end

  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      state_reg     <= S_IDLE;
      ptr_reg       <= 8'd0;
      timer_reg     <= 16'd0;
      idx_reg       <= 8'd0;
      cpu_rst_n_reg <= 1'b0;
      ld_ready_reg  <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_adrs_reg  <= 8'd0;
      mem_wdata_reg <= 8'd0;
      resad_reg     <= 8'd0;
      dmp_valid_reg <= 1'b0;
      dmp_data_reg  <= 8'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      timer_reg     <= timer_next;
      idx_reg       <= idx_next;
      cpu_rst_n_reg <= cpu_rst_n_next;
      ld_ready_reg  <= ld_ready_next;
      mem_we_reg    <= mem_we_next;
      mem_adrs_reg  <= mem_adrs_next;
      mem_wdata_reg <= mem_wdata_next;
      resad_reg     <= resad_next;
      dmp_valid_reg <= dmp_valid_next;
      dmp_data_reg  <= dmp_data_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      timeout_reg   <= timeout_next;
    end
  end

  // The core owns the memory port combinationally only while running.
  assign mem_adrs  = (state_reg == S_RUN) ? cpu_adrs    : mem_adrs_reg;
  assign mem_wdata = (state_reg == S_RUN) ? cpu_wdata   : mem_wdata_reg;
  assign mem_we    = (state_reg == S_RUN) ? cpu_mmwr_en : mem_we_reg;

  assign ld_ready  = ld_ready_reg;
  assign cpu_rst_N = cpu_rst_n_reg;
  assign resad     = resad_reg;
  assign dmp_valid = dmp_valid_reg;
  assign dmp_data  = dmp_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign timeout   = timeout_reg;

endmodule
